fpu_mul_seq: RTL and testbench
==============================

# fpu_mul_seq

Multi-cycle IEEE-754 single-precision multiplier for the RV32IMF FPU, the counterpart of the Newton-Raphson divider's reciprocal path. It takes two operands on a start strobe and forms the 24×24 mantissa product by shift-and-add, one bit per cycle. It then normalises, truncates, packs and signals done. It serves FMUL in area-constrained builds where a combinational multiplier array is too large, and uses the same zero/denormal flush policy as the divider.

## Interface
- No parameters.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; operands sampled when start=1 in IDLE or DONE.
- N1  in  32  multiplicand, IEEE-754 single.
- N2  in  32  multiplier, IEEE-754 single.
- result  out  32  registered product; holds last value until next completion; reset 0x00000000.
- busy  out  1  high in MUL and NORM; reset 0.
- done  out  1  one-cycle pulse, high exactly in DONE; reset 0.

## Operation
- States: IDLE, MUL, NORM, DONE. Reset → IDLE, counter=0, accumulator=0, result=0.
- IDLE/DONE with start=1: latch sign = N1[31]^N2[31] and exp_sum = N1[30:23] + N2[30:23] − 127 (10-bit signed). Latch mantissas {1,N[22:0]}.
  - Special cases, checked in priority order; each goes straight to DONE and loads result:
    - either operand NaN (exp 255, frac≠0) → 0x7FC00000.
    - one operand Inf, the other exp 0 → 0x7FC00000.
    - either operand Inf → {sign,0x7F800000}.
    - either operand exp 0 (zero/denormal) → 0x00000000. Sign is dropped, as in the divider.
  - Otherwise → MUL.
- DONE with start=0 → IDLE. start is ignored in MUL and NORM; no queueing.
- MUL: 24 iterations over a 48-bit accumulator.
  - Each cycle: if multiplier LSB=1, add the multiplicand shifted left by the counter; then shift the multiplier right by 1.
  - Counter runs 0..23; on counter=23 → NORM.
- NORM: P = 48-bit product.
  - P[47]=1 → frac = P[46:24], e = exp_sum+1.
  - P[47]=0 → frac = P[45:23], e = exp_sum.
  - Rounding is truncation (round toward zero).
  - e ≥ 255 → {sign,0x7F800000}. e ≤ 0 → 0x00000000. Else {sign, e[7:0], frac}.
  - Load result, → DONE.
- Width rules: exp_sum must not wrap. Compute it zero-extended to 10 bits, then subtract 127.

## Timing
- Start sampled at edge 0.
  - Normal path: MUL during cycles 1–24, NORM cycle 25, done=1 and result valid in cycle 26.
  - Special path: done=1 and result valid in cycle 1.
- busy rises in the cycle after start is accepted and falls when DONE is entered.
- Back-to-back: start asserted during the DONE cycle is accepted; the next operation begins with no idle gap.
- Reset mid-operation: the next cycle is IDLE with busy=0, done=0 and result=0. No done pulse is produced for the aborted operation.
- Operand inputs may change freely after the accepting edge.

## Structure
- Shared package fpu_pkg holds:
  - Constants: FP_QNAN=32'h7FC00000, FP_INF=31'h7F800000, FP_BIAS=127.
  - State enum (IDLE, MUL, NORM, DONE).
  - Classify helper functions: is_nan, is_inf, is_zero_or_denorm.
- One combinational sub-module, fpu_mul_special: takes N1 and N2; outputs special_hit and special_result. It is reused by the combinational multiplier.
- Datapath registers: 48-bit accumulator, 24-bit shifting multiplier, 24-bit multiplicand, 5-bit counter, 10-bit exponent, sign, 2-bit state.

## Test plan
- 0x40400000 × 0x40000000 (3.0×2.0) → result 0x40C00000, done at cycle 26, busy high in cycles 1–25.
- 0x3FC00000 × 0x3FC00000 (1.5×1.5, P[47]=1 path) → 0x40100000; 0xBF800000 × 0x3F800000 → 0xBF800000.
- 0x7F000000 × 0x40000000 → overflow 0x7F800000; 0x00800000 × 0x00800000 → underflow 0x00000000.
- Special cases, each with done at cycle 1:
  - 0x00000000 × 0x40400000 → 0x00000000.
  - 0x7F800000 × 0x00000000 → 0x7FC00000.
  - 0xFF800000 × 0x40000000 → 0xFF800000.
- Re-start and abort behaviour:
  - start pulsed in cycle 5 of an operation with different operands → ignored; the original result is returned at cycle 26.
  - start held through DONE → a second operation is accepted with no gap.
- rst asserted in cycle 10 of an operation → next cycle busy=0, done=0, result=0x00000000; no later done pulse.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE-754 single constants, sequencer states and
// operand classification helpers used by the multiplier and divider paths.
package fpu_pkg;

   localparam logic [31:0] FP_QNAN = 32'h7FC00000;
   localparam logic [30:0] FP_INF  = 31'h7F800000;
   localparam logic [9:0]  FP_BIAS = 10'd127;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      NORM = 2'd2,
      DONE = 2'd3
   } state_t;

   function automatic logic is_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
   endfunction

   function automatic logic is_inf(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
   endfunction

   // Denormals are flushed, so they classify together with true zero
   function automatic logic is_zero_or_denorm(input logic [31:0] x);
      return x[30:23] == 8'h00;
   endfunction

endpackage

// File: rtl/fpu_mul_special.sv
// Combinational special-operand detection for FMUL; shared by the sequential
// and combinational multipliers so both give identical NaN/Inf/zero answers.
module fpu_mul_special
   import fpu_pkg::*;
(
   input  logic [31:0] N1,
   input  logic [31:0] N2,
   output logic        special_hit,
   output logic [31:0] special_result
);

   logic sign;

   assign sign = N1[31] ^ N2[31];

   // Priority order matters: Inf x 0 must yield NaN before the plain Inf rule
   always_comb begin
      special_hit    = 1'b1;
      special_result = 32'h00000000;
      if (is_nan(N1) || is_nan(N2)) begin
         special_result = FP_QNAN;
      end else if ((is_inf(N1) && is_zero_or_denorm(N2)) ||
                   (is_inf(N2) && is_zero_or_denorm(N1))) begin
         special_result = FP_QNAN;
      end else if (is_inf(N1) || is_inf(N2)) begin
         special_result = {sign, FP_INF};
      end else if (is_zero_or_denorm(N1) || is_zero_or_denorm(N2)) begin
         special_result = 32'h00000000;
      end else begin
         special_hit = 1'b0;
      end
   end

endmodule

// File: rtl/fpu_mul_seq.sv
// Area-lean FMUL: 24x24 shift-and-add mantissa product, one bit per cycle,
// then normalise, truncate and pack. Special operands finish in one cycle.
module fpu_mul_seq
   import fpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] N1,
   input  logic [31:0] N2,
   output logic [31:0] result,
   output logic        busy,
   output logic        done
);

   state_t             state;
   logic [47:0]        acc;
   logic [23:0]        mplier;
   logic [23:0]        mcand;
   logic [4:0]         count;
   logic signed [9:0]  exp_sum;
   logic               sign;

   logic               special_hit;
   logic [31:0]        special_result;
   logic               accept;
   logic signed [9:0]  norm_exp;
   logic [22:0]        norm_frac;
   logic [31:0]        norm_result;

   fpu_mul_special u_special (
      .N1             (N1),
      .N2             (N2),
      .special_hit    (special_hit),
      .special_result (special_result)
   );

   assign accept = start && ((state == IDLE) || (state == DONE));
   assign busy   = (state == MUL) || (state == NORM);
   assign done   = (state == DONE);

   // A product in [2,4) carries one extra integer bit, bumping the exponent
   always_comb begin
      norm_exp    = exp_sum + $signed({9'd0, acc[47]});
      norm_frac   = acc[47] ? acc[46:24] : acc[45:23];
      norm_result = {sign, norm_exp[7:0], norm_frac};
      if (norm_exp >= 10'sd255) begin
         norm_result = {sign, FP_INF};
      end else if (norm_exp <= 10'sd0) begin
         norm_result = 32'h00000000;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         acc     <= '0;
         mplier  <= '0;
         mcand   <= '0;
         count   <= '0;
         exp_sum <= '0;
         sign    <= 1'b0;
         result  <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  sign    <= N1[31] ^ N2[31];
                  exp_sum <= $signed({2'b00, N1[30:23]} + {2'b00, N2[30:23]} - FP_BIAS);
                  mcand   <= {1'b1, N1[22:0]};
                  mplier  <= {1'b1, N2[22:0]};
                  acc     <= '0;
                  count   <= '0;
                  if (special_hit) begin
                     result <= special_result;
                     state  <= DONE;
                  end else begin
                     state  <= MUL;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            MUL: begin
               if (mplier[0]) begin
                  acc <= acc + ({24'd0, mcand} << count);
               end
               mplier <= mplier >> 1;
               count  <= count + 5'd1;
               if (count == 5'd23) begin
                  state <= NORM;
               end
            end
            NORM: begin
               result <= norm_result;
               state  <= DONE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_mul_seq.sv
// Directed self-checking bench for fpu_mul_seq: scoreboard of expected
// products, latency/busy checks, restart-ignore, back-to-back and abort.
module tb_fpu_mul_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] N1;
   logic [31:0] N2;
   logic [31:0] result;
   logic        busy;
   logic        done;

   int          checks;
   int          failures;
   logic [31:0] sb_q[$];

   fpu_mul_seq dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .N1     (N1),
      .N2     (N2),
      .result (result),
      .busy   (busy),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // Drive operands with start for one edge (edge 0); returns in cycle 1
   task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_v);
      start = 1'b1;
      N1    = a;
      N2    = b;
      sb_q.push_back(exp_v);
      @(posedge clk);
      #1;
      start = 1'b0;
      N1    = $urandom;
      N2    = $urandom;
   endtask

   // Called in cycle 1; waits for done, checking latency, busy length and result
   task automatic wait_done(input string tag, input int exp_cycles, input int exp_busy,
                            input int restart_cycle);
      int          cycles;
      int          busy_cnt;
      logic [31:0] exp_v;
      cycles   = 1;
      busy_cnt = 0;
      while (done !== 1'b1 && cycles < 200) begin
         if (busy === 1'b1) busy_cnt++;
         if (cycles == restart_cycle) begin
            start = 1'b1;
            N1    = 32'h40A00000;
            N2    = 32'h40E00000;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         cycles++;
      end
      start = 1'b0;
      exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hxxxxxxxx;
      check_output({tag, "_done"}, {31'd0, done}, 32'd1);
      check_output({tag, "_latency"}, 32'(cycles), 32'(exp_cycles));
      check_output({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
      check_output({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
      check_output({tag, "_result"}, result, exp_v);
   endtask

   initial begin
      int pulses;
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      start    = 1'b0;
      N1       = 32'h0;
      N2       = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check_output("reset_result", result, 32'h00000000);
      check_output("reset_busy", {31'd0, busy}, 32'd0);
      check_output("reset_done", {31'd0, done}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Normal path: 26-cycle latency, busy for cycles 1..25
      apply_stimulus(32'h40400000, 32'h40000000, 32'h40C00000);
      wait_done("mul_3x2", 26, 25, 0);
      check_output("done_one_cycle_low", 32'(0), 32'(0));
      @(posedge clk);
      #1;
      check_output("done_pulse_width", {31'd0, done}, 32'd0);
      check_output("result_held", result, 32'h40C00000);

      apply_stimulus(32'h3FC00000, 32'h3FC00000, 32'h40100000);
      wait_done("mul_1p5sq", 26, 25, 0);
      apply_stimulus(32'hBF800000, 32'h3F800000, 32'hBF800000);
      wait_done("mul_neg1", 26, 25, 0);
      apply_stimulus(32'h7F000000, 32'h40000000, 32'h7F800000);
      wait_done("overflow", 26, 25, 0);
      apply_stimulus(32'h00800000, 32'h00800000, 32'h00000000);
      wait_done("underflow", 26, 25, 0);

      // Special operands finish at cycle 1
      apply_stimulus(32'h00000000, 32'h40400000, 32'h00000000);
      wait_done("zero_x_3", 1, 0, 0);
      apply_stimulus(32'h7F800000, 32'h00000000, 32'h7FC00000);
      wait_done("inf_x_zero", 1, 0, 0);
      apply_stimulus(32'hFF800000, 32'h40000000, 32'hFF800000);
      wait_done("neginf_x_2", 1, 0, 0);
      apply_stimulus(32'h7FC00001, 32'h3F800000, 32'h7FC00000);
      wait_done("nan_x_1", 1, 0, 0);

      // A start pulse mid-operation must be ignored
      @(posedge clk);
      #1;
      apply_stimulus(32'h40400000, 32'h40000000, 32'h40C00000);
      wait_done("restart_ignored", 26, 25, 5);
      @(posedge clk);
      #1;
      check_output("no_extra_done", {31'd0, done | busy}, 32'd0);

      // Start held in DONE launches the next operation with no gap
      apply_stimulus(32'h3FC00000, 32'h3FC00000, 32'h40100000);
      wait_done("b2b_first", 26, 25, 0);
      apply_stimulus(32'hC0400000, 32'h40000000, 32'hC0C00000);
      check_output("b2b_busy_next", {31'd0, busy}, 32'd1);
      wait_done("b2b_second", 26, 25, 0);

      // Reset in cycle 10 aborts silently
      @(posedge clk);
      #1;
      apply_stimulus(32'h40400000, 32'h40400000, 32'h41100000);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      void'(sb_q.pop_front());
      check_output("abort_busy", {31'd0, busy}, 32'd0);
      check_output("abort_done", {31'd0, done}, 32'd0);
      check_output("abort_result", result, 32'h00000000);
      pulses = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) pulses++;
      end
      check_output("abort_no_done", 32'(pulses), 32'd0);

      apply_stimulus(32'h40400000, 32'h40400000, 32'h41100000);
      wait_done("after_abort", 26, 25, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
